// File: rtl/pacman_motion.sv
// Pacman sprite motion: button sync/debounce, heading latch, ticked stepping with
// playfield clamping, and the animation-frame toggle feeding drawcon.

module pacman_debounce #(
  parameter int DEB_BITS = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);
  logic [1:0]          sync;
  logic [DEB_BITS-1:0] cnt;

  // Level flips only after 2^DEB_BITS consecutive mismatching samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (&cnt) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module pacman_motion #(
  parameter int DEB_BITS = 16,
  parameter int X_INIT   = 471,
  parameter int Y_INIT   = 386,
  parameter int X_MIN    = 0,
  parameter int X_MAX    = 1247,
  parameter int Y_MIN    = 0,
  parameter int Y_MAX    = 991,
  parameter int STEP     = 1,
  parameter int ANIM_DIV = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_u,
  input  logic        btn_d,
  input  logic        btn_l,
  input  logic        btn_r,
  input  logic        tick,
  output logic [10:0] pos_x,
  output logic [9:0]  pos_y,
  output logic [3:0]  dir,
  output logic        moving
);
  localparam logic [2:0] HD_R = 3'b000;
  localparam logic [2:0] HD_L = 3'b010;
  localparam logic [2:0] HD_D = 3'b011;
  localparam logic [2:0] HD_U = 3'b100;

  localparam int AW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [AW-1:0] ANIM_LAST = AW'(ANIM_DIV - 1);

  localparam logic [10:0] XMIN_P = 11'(X_MIN);
  localparam logic [10:0] XMAX_P = 11'(X_MAX);
  localparam logic [9:0]  YMIN_P = 10'(Y_MIN);
  localparam logic [9:0]  YMAX_P = 10'(Y_MAX);
  localparam logic [11:0] STEP_X = 12'(STEP);
  localparam logic [10:0] STEP_Y = 11'(STEP);

  typedef enum logic {IDLE, MOVE} state_t;

  state_t        state, state_nxt;
  logic [3:0]    btn_raw, deb;
  logic [2:0]    heading, heading_nxt;
  logic          frame, frame_nxt;
  logic [AW-1:0] anim_cnt, anim_nxt;
  logic [10:0]   x_nxt;
  logic [9:0]    y_nxt;
  logic [11:0]   x_inc, x_dec;
  logic [10:0]   y_inc, y_dec;

  // Lane order: 0 right, 1 left, 2 down, 3 up.
  assign btn_raw = {btn_u, btn_d, btn_l, btn_r};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    pacman_debounce #(.DEB_BITS(DEB_BITS)) u_deb (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn_raw[i]),
      .level (deb[i])
    );
  end

  always_comb begin
    heading_nxt = heading;
    if      (deb[2]) heading_nxt = HD_D;
    else if (deb[3]) heading_nxt = HD_U;
    else if (deb[1]) heading_nxt = HD_L;
    else if (deb[0]) heading_nxt = HD_R;
  end

  // One bit of headroom: a set MSB on the decrement is a borrow, i.e. below zero.
  assign x_inc = {1'b0, pos_x} + STEP_X;
  assign x_dec = {1'b0, pos_x} - STEP_X;
  assign y_inc = {1'b0, pos_y} + STEP_Y;
  assign y_dec = {1'b0, pos_y} - STEP_Y;

  always_comb begin
    state_nxt = state;
    x_nxt     = pos_x;
    y_nxt     = pos_y;
    frame_nxt = frame;
    anim_nxt  = anim_cnt;
    case (state)
      IDLE: if (|deb) state_nxt = MOVE;
      MOVE: begin
        if (tick) begin
          if (anim_cnt == ANIM_LAST) begin
            anim_nxt  = '0;
            frame_nxt = ~frame;
          end else begin
            anim_nxt = anim_cnt + 1'b1;
          end
          // Registered heading: a same-cycle heading change steps the old way.
          case (heading)
            HD_R: begin
              if (x_inc > {1'b0, XMAX_P}) begin
                x_nxt     = XMAX_P;
                state_nxt = IDLE;
              end else begin
                x_nxt = x_inc[10:0];
              end
            end
            HD_L: begin
              if (x_dec[11] || (x_dec < {1'b0, XMIN_P})) begin
                x_nxt     = XMIN_P;
                state_nxt = IDLE;
              end else begin
                x_nxt = x_dec[10:0];
              end
            end
            HD_D: begin
              if (y_inc > {1'b0, YMAX_P}) begin
                y_nxt     = YMAX_P;
                state_nxt = IDLE;
              end else begin
                y_nxt = y_inc[9:0];
              end
            end
            HD_U: begin
              if (y_dec[10] || (y_dec < {1'b0, YMIN_P})) begin
                y_nxt     = YMIN_P;
                state_nxt = IDLE;
              end else begin
                y_nxt = y_dec[9:0];
              end
            end
            default: ;
          endcase
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      heading  <= HD_R;
      frame    <= 1'b0;
      anim_cnt <= '0;
      pos_x    <= 11'(X_INIT);
      pos_y    <= 10'(Y_INIT);
    end else begin
      state    <= state_nxt;
      heading  <= heading_nxt;
      frame    <= frame_nxt;
      anim_cnt <= anim_nxt;
      pos_x    <= x_nxt;
      pos_y    <= y_nxt;
    end
  end

  assign dir    = {heading, frame};
  assign moving = (state == MOVE);
endmodule

// File: tb/tb_pacman_motion.sv
// Scoreboard bench: two pacman_motion instances share stimulus; expectations are
// queued as stimulus is driven and drained against the outputs afterwards.

module tb_pacman_motion;
  logic clk = 1'b0;
  logic rst, btn_u, btn_d, btn_l, btn_r, tick;

  logic [10:0] a_x, b_x;
  logic [9:0]  a_y, b_y;
  logic [3:0]  a_dir, b_dir;
  logic        a_mov, b_mov;

  int n_tests = 0;
  int n_fail  = 0;

  localparam int S_AX = 0, S_AY = 1, S_AD = 2, S_AM = 3, S_BX = 4, S_BM = 5, S_BD = 6;

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  pacman_motion #(.DEB_BITS(2), .ANIM_DIV(4)) dut_a (
    .clk(clk), .rst(rst), .btn_u(btn_u), .btn_d(btn_d), .btn_l(btn_l), .btn_r(btn_r),
    .tick(tick), .pos_x(a_x), .pos_y(a_y), .dir(a_dir), .moving(a_mov)
  );

  pacman_motion #(.DEB_BITS(2), .X_MAX(473), .STEP(2)) dut_b (
    .clk(clk), .rst(rst), .btn_u(btn_u), .btn_d(btn_d), .btn_l(btn_l), .btn_r(btn_r),
    .tick(tick), .pos_x(b_x), .pos_y(b_y), .dir(b_dir), .moving(b_mov)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int sig);
    case (sig)
      S_AX:    return 32'(a_x);
      S_AY:    return 32'(a_y);
      S_AD:    return 32'(a_dir);
      S_AM:    return 32'(a_mov);
      S_BX:    return 32'(b_x);
      S_BM:    return 32'(b_mov);
      S_BD:    return 32'(b_dir);
      default: return 32'hdead_beef;
    endcase
  endfunction

  task automatic push(input string tag, input int sig, input logic [31:0] e);
    exp_t x;
    x.tag = tag;
    x.sig = sig;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, observe(e.sig), e.exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // mask = {u, d, l, r}
  task automatic press(input logic [3:0] mask, input int n);
    {btn_u, btn_d, btn_l, btn_r} = mask;
    cyc(n);
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    cyc(1);
  endtask

  initial begin
    rst = 1'b1;
    {btn_u, btn_d, btn_l, btn_r} = 4'b0000;
    tick = 1'b0;
    cyc(3);
    push("rst_ax", S_AX, 471);
    push("rst_ay", S_AY, 386);
    push("rst_ad", S_AD, 4'b0000);
    push("rst_am", S_AM, 0);
    push("rst_bx", S_BX, 471);
    drain();
    rst = 1'b0;
    cyc(2);

    // 3-cycle glitch must be rejected
    press(4'b0010, 3);
    press(4'b0000, 12);
    push("glitch_ad", S_AD, 4'b0000);
    push("glitch_am", S_AM, 0);
    drain();

    press(4'b0010, 10);
    push("left_ad", S_AD, 4'b0100);
    push("left_am", S_AM, 1);
    push("left_bm", S_BM, 1);
    drain();
    press(4'b0000, 10);

    press(4'b1100, 10);
    push("prio_du", S_AD, 4'b0110);
    drain();
    press(4'b1000, 10);
    push("prio_u", S_AD, 4'b1000);
    drain();
    press(4'b0000, 10);

    // Buttons alone never move the sprite
    press(4'b0001, 10);
    press(4'b0000, 10);
    push("right_ad", S_AD, 4'b0000);
    push("noTick_ax", S_AX, 471);
    push("noTick_bx", S_BX, 471);
    drain();

    for (int k = 1; k <= 5; k++) begin
      pulse_tick();
      case (k)
        1: begin push("clamp1_bx", S_BX, 473); push("clamp1_bm", S_BM, 1); end
        2: begin push("clamp2_bx", S_BX, 473); push("clamp2_bm", S_BM, 0); end
        3: push("anim3_ad", S_AD, 4'b0000);
        4: push("anim4_ad", S_AD, 4'b0001);
        5: begin
          push("move5_ax", S_AX, 476);
          push("move5_ay", S_AY, 386);
          push("idle5_bx", S_BX, 473);
        end
        default: ;
      endcase
      drain();
    end

    press(4'b0010, 10);
    press(4'b0000, 10);
    push("reenter_bm", S_BM, 1);
    push("reenter_bd", S_BD, 4'b0100);
    push("turn_ad", S_AD, 4'b0101);
    drain();

    // b walks 473 -> 1 in 236 ticks, then 1-2 must clamp to 0, not wrap
    for (int i = 1; i <= 237; i++) begin
      pulse_tick();
      if (i == 236) begin
        push("walk_bx", S_BX, 1);
        push("walk_bm", S_BM, 1);
        drain();
      end
    end
    push("under_bx", S_BX, 0);
    push("under_bm", S_BM, 0);
    push("walk_ax", S_AX, 239);
    // a has seen 242 ticks in MOVE: 60 toggles, frame back to 0
    push("walk_ad", S_AD, 4'b0100);
    drain();

    pulse_tick();
    push("idleTick_bx", S_BX, 0);
    push("idleTick_bm", S_BM, 0);
    push("idleTick_ax", S_AX, 238);
    drain();

    // Async reset mid-motion, no clock edge in between
    rst = 1'b1;
    #1;
    push("arst_ax", S_AX, 471);
    push("arst_ay", S_AY, 386);
    push("arst_ad", S_AD, 4'b0000);
    push("arst_am", S_AM, 0);
    push("arst_bx", S_BX, 471);
    drain();
    cyc(2);
    rst = 1'b0;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
